// File: rtl/effect_sample_feeder.sv
// Buffers receiver samples in a small FIFO and offers them one at a time to an effect
// (data_ready / read_enable / read_done), returning processed samples. Option: EFFECT_FEEDER_BYPASS_EN.
module effect_sample_feeder #(
  parameter int D_WIDTH = 16,
  parameter int FIFO_AW = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [D_WIDTH-1:0] i_sample,
  input  logic                      i_sample_valid,
  output logic                      o_data_ready,
  output logic signed [D_WIDTH-1:0] o_data,
  input  logic                      i_read_enable,
  output logic                      o_read_done,
  input  logic signed [D_WIDTH-1:0] i_fx_data,
  input  logic                      i_fx_valid,
`ifdef EFFECT_FEEDER_BYPASS_EN
  input  logic                      i_bypass,
`endif
  output logic signed [D_WIDTH-1:0] o_sample,
  output logic                      o_sample_valid,
  output logic [FIFO_AW:0]          o_fill,
  output logic                      o_overflow
);

  localparam int DEPTH = 2**FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, OFFER, ACK} state_t;

  state_t               state_q, state_d;
  logic [D_WIDTH-1:0]   mem_q [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]     fill_q, fill_d;
  logic [D_WIDTH-1:0]   data_q, sample_q;
  logic                 sample_valid_q, overflow_q;
  logic                 bypass, empty, full, pop, push, drop;

`ifdef EFFECT_FEEDER_BYPASS_EN
  assign bypass = i_bypass;
`else
  assign bypass = 1'b0;
`endif

  // The head is only taken when no sample is currently on offer (IDLE or ACK).
  assign empty = (fill_q == '0);
  assign full  = (fill_q == FULL_LVL);
  assign pop   = (state_q != OFFER) && !empty;
  assign push  = i_sample_valid && (!full || pop);
  assign drop  = i_sample_valid && full && !pop;

  always_comb begin
    fill_d = fill_q;
    if (push && !pop)      fill_d = fill_q + 1'b1;
    else if (pop && !push) fill_d = fill_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = OFFER;
      OFFER:   if (i_read_enable || bypass) state_d = ACK;
      ACK:     state_d = empty ? IDLE : OFFER;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_data_ready = (state_q == OFFER);
    o_read_done  = (state_q == ACK);
  end

  // Storage array carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= i_sample;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      fill_q <= fill_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        data_q   <= mem_q[rd_ptr_q];
      end
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Return path; in bypass the offered sample itself is returned during ACK.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else if (bypass) begin
      sample_valid_q <= (state_q == OFFER);
      if (state_q == OFFER) sample_q <= data_q;
    end else begin
      sample_valid_q <= i_fx_valid;
      if (i_fx_valid) sample_q <= i_fx_data;
    end
  end

  assign o_data         = data_q;
  assign o_sample       = sample_q;
  assign o_sample_valid = sample_valid_q;
  assign o_fill         = fill_q;
  assign o_overflow     = overflow_q;

endmodule

// File: tb/tb_effect_sample_feeder.sv
// Scoreboard bench for effect_sample_feeder: queue-based reference model, decoupled monitor.
module tb_effect_sample_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] i_sample = '0;
  logic        i_sample_valid = 1'b0;
  logic        o_data_ready;
  logic [15:0] o_data;
  logic        i_read_enable = 1'b0;
  logic        o_read_done;
  logic [15:0] i_fx_data = '0;
  logic        i_fx_valid = 1'b0;
  logic [15:0] o_sample;
  logic        o_sample_valid;
  logic [3:0]  o_fill;
  logic        o_overflow;
  logic        i_bypass = 1'b0;

  always #5 clk = ~clk;

  effect_sample_feeder #(.D_WIDTH(16), .FIFO_AW(3)) dut (
    .clk(clk), .reset(reset),
    .i_sample(i_sample), .i_sample_valid(i_sample_valid),
    .o_data_ready(o_data_ready), .o_data(o_data),
    .i_read_enable(i_read_enable), .o_read_done(o_read_done),
    .i_fx_data(i_fx_data), .i_fx_valid(i_fx_valid),
`ifdef EFFECT_FEEDER_BYPASS_EN
    .i_bypass(i_bypass),
`endif
    .o_sample(o_sample), .o_sample_valid(o_sample_valid),
    .o_fill(o_fill), .o_overflow(o_overflow)
  );

  int tests = 0;
  int fails = 0;
  int exp_offer_q[$];
  int exp_ret_q[$];

  // Reference model: FIFO contents as a queue, plus whether a sample is on offer / being acked.
  int model_q[$];
  bit m_offer, m_ack, m_ovf, m_sval;
  int m_data, m_sample;
  int takes = 0;
  int done_cnt = 0;
  bit prev_rdy = 1'b0;

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(bit rst, bit sv, int smp, bit re, bit fxv, int fxd);
    bit pop;
    @(negedge clk);
    chk("fill", int'(o_fill), model_q.size());
    chk("overflow", int'(o_overflow), int'(m_ovf));
    chk("data_ready", int'(o_data_ready), int'(m_offer));
    chk("read_done", int'(o_read_done), int'(m_ack));
    chk("data", int'(o_data), m_data);
    chk("sample", int'(o_sample), m_sample);
    chk("sample_valid", int'(o_sample_valid), int'(m_sval));
    reset          = rst;
    i_sample_valid = sv;
    i_sample       = smp[15:0];
    i_read_enable  = re;
    i_fx_valid     = fxv;
    i_fx_data      = fxd[15:0];
    if (rst) begin
      model_q.delete();
      m_offer = 0; m_ack = 0; m_ovf = 0; m_sval = 0;
      m_data = 0; m_sample = 0;
      return;
    end
    pop = !m_offer && (model_q.size() > 0);
    if (m_offer) begin
      if (re) begin
        m_offer = 0;
        m_ack   = 1;
        takes++;
      end
    end else begin
      m_ack = 0;
      if (pop) begin
        m_data = model_q.pop_front();
        exp_offer_q.push_back(m_data);
        m_offer = 1;
      end
    end
    if (sv) begin
      if (model_q.size() < 8 || pop) model_q.push_back(smp & 16'hFFFF);
      else m_ovf = 1;
    end
    m_sval = fxv;
    if (fxv) begin
      m_sample = fxd & 16'hFFFF;
      exp_ret_q.push_back(m_sample);
    end
  endtask

  // Monitor: every new offer and every return strobe is matched against the scoreboard.
  always @(negedge clk) begin
    if (o_data_ready && !prev_rdy) begin
      if (exp_offer_q.size() == 0) chk("offer_unexpected", 1, 0);
      else chk("offer", int'(o_data), exp_offer_q.pop_front());
    end
    prev_rdy <= o_data_ready;
    if (o_sample_valid) begin
      if (exp_ret_q.size() == 0) chk("return_unexpected", 1, 0);
      else chk("return", int'(o_sample), exp_ret_q.pop_front());
    end
    if (o_read_done) done_cnt++;
  end

  initial begin
    repeat (2) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // single sample with read_enable tied high
    cyc(0, 1, 'h1234, 1, 0, 0);
    repeat (6) cyc(0, 0, 0, 1, 0, 0);
    // fill to full, then overflow
    for (int k = 1; k <= 9; k++) cyc(0, 1, k, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 10, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    repeat (25) cyc(0, 0, 0, 1, 0, 0);
    // strobe coinciding with the ACK pop at full occupancy
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) cyc(0, 1, 'h20 + k, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 'h55, 0, 0, 0);
    repeat (25) cyc(0, 0, 0, 1, 0, 0);
    // return path extremes, back to back
    cyc(0, 0, 0, 0, 1, 'h8000);
    cyc(0, 0, 0, 0, 1, 'h7FFF);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    // reset while offering with three samples buffered
    for (int k = 1; k <= 4; k++) cyc(0, 1, 'hA0 + k, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 1, 0, 0);
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      cyc(0, bit'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
          ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 3),
          int'($urandom_range(0, 65535)));
    end
    repeat (30) cyc(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    #1;
    chk("offers_pending", exp_offer_q.size(), 0);
    chk("returns_pending", exp_ret_q.size(), 0);
    chk("done_count", done_cnt, takes);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/effect_sample_feeder.md
# effect_sample_feeder

Controller-side endpoint of the effect handshake. Buffers incoming audio samples from the receiver in a small FIFO and offers them one at a time to an effect through the `data_ready` / `read_enable` / `read_done` handshake. Captures the effect's processed samples for the playback path. It sits between the audio input stream and an effect block such as the clipping effect, and drives the effect's input-side ports.

## Interface
- `D_WIDTH`, 16: sample width, signed two's complement.
- `FIFO_AW`, 3: FIFO address width; depth = 2**FIFO_AW (8).

Ports (clock and reset first):
- `clk`  in  1  system clock; the single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `i_sample`  in  D_WIDTH  signed sample from the audio receiver.
- `i_sample_valid`  in  1  one-cycle strobe: `i_sample` is valid.
- `o_data_ready`  out  1  offered sample is on `o_data`; drives the effect's `i_data_ready`.
- `o_data`  out  D_WIDTH  offered sample; drives the effect's `i_data`.
- `i_read_enable`  in  1  effect takes the offered sample; from the effect's `o_read_enable`.
- `o_read_done`  out  1  one-cycle acknowledge of a take; drives the effect's `i_read_done`.
- `i_fx_data`  in  D_WIDTH  processed sample from the effect's `o_data`.
- `i_fx_valid`  in  1  from the effect's `o_data_valid`.
- `o_sample`  out  D_WIDTH  processed sample to the playback path.
- `o_sample_valid`  out  1  one-cycle strobe for `o_sample`.
- `o_fill`  out  FIFO_AW+1  FIFO occupancy. Excludes the offered-sample register.
- `o_overflow`  out  1  sticky; set when an input sample is dropped.

## Operation
**FIFO**
- Write on `i_sample_valid` when not full.
- Write when full and no pop in the same cycle: sample dropped, `o_overflow` set.
- Write when full with a pop in the same cycle: write accepted, `o_fill` unchanged.
- Simultaneous write and pop at any fill level: `o_fill` unchanged.
- Pointers wrap modulo depth. Full is `o_fill == 2**FIFO_AW`; empty is `o_fill == 0`.

**FSM** (states IDLE, OFFER, ACK)
- IDLE: `o_data_ready=0`. If the FIFO is non-empty: pop the head into the `o_data` register and go to OFFER.
- OFFER: `o_data_ready=1`, `o_data` held stable. On `i_read_enable=1`, go to ACK. Otherwise stay; there is no timeout.
- ACK: `o_read_done=1`, `o_data_ready=0`.
  - If the FIFO is non-empty: pop the next head into `o_data` and go to OFFER.
  - Otherwise go to IDLE. `o_data` keeps its last value.
- `i_read_enable` outside OFFER is ignored.

**Return path**
- On `i_fx_valid=1`: register `i_fx_data` into `o_sample`; `o_sample_valid=1` the next cycle, for one cycle.
- Back-to-back `i_fx_valid` gives back-to-back strobes.
- The return path is independent of FSM state.

**Arithmetic**
- Samples pass bit-exact; no scaling or saturation.
- `o_fill` is unsigned and counts 0..2**FIFO_AW.

## Timing
- Reset values: `o_data_ready=0`, `o_data=0`, `o_read_done=0`, `o_sample=0`, `o_sample_valid=0`, `o_fill=0`, `o_overflow=0`. FSM=IDLE, FIFO pointers=0.
- Reset takes effect at the first rising edge with `reset=1`.
- Reset mid-offer discards the offered sample and all FIFO contents. No `o_read_done` is issued for it.
- Latency, `i_sample_valid` at edge N on an empty FIFO:
  - `o_fill=1` after edge N.
  - `o_data_ready=1` after edge N+1.
- `i_read_enable` sampled at edge M in OFFER:
  - `o_read_done=1` and `o_data_ready=0` during cycle M+1.
  - Next offer visible after edge M+1 if the FIFO is non-empty.
- Maximum throughput: one sample every 2 cycles (mandatory ACK bubble).
- Return-path latency: exactly 1 cycle.

## Configuration
- `EFFECT_FEEDER_BYPASS_EN` defined:
  - Adds input port `i_bypass` (1 bit).
  - When `i_bypass=1`, the FSM auto-completes each offer: OFFER goes to ACK the cycle after entry without waiting for `i_read_enable`.
  - The offered sample is written to `o_sample`, with `o_sample_valid` pulsing in the ACK cycle.
  - `i_fx_valid` is ignored while `i_bypass=1`.
- Macro not defined: no `i_bypass` port; the FSM always waits for `i_read_enable`.

## Test plan
- Reset, then one sample 16'h1234 with `i_read_enable` tied high -> `o_data_ready` and `o_data=16'h1234` 2 cycles after the strobe; `o_read_done` pulses once; back to IDLE with `o_fill=0`.
- 9 strobes, no reads, samples 1..9 -> sample 1 offered, `o_fill=8` after sample 9, `o_overflow=0`. A 10th strobe -> dropped, `o_overflow=1`, `o_fill` stays 8.
- Full FIFO with `i_read_enable=1` -> offers arrive every 2 cycles in order 1..9; `o_read_done` count equals offers taken.
- Strobe in the same cycle as the ACK pop at `o_fill=8` -> sample accepted, `o_fill` stays 8, no overflow.
- `i_fx_valid` pulses with 16'h8000 then 16'h7FFF on consecutive cycles -> `o_sample` shows both values exactly, two consecutive `o_sample_valid` strobes.
- `reset` asserted during OFFER with `o_fill=3` -> all outputs zero the next cycle; the old sample is never acknowledged.
